// File: rtl/uart_pkg.sv
// Shared UART definitions: parity modes, serialiser state encoding, parity helper.
package uart_pkg;

  localparam int unsigned PAR_NONE = 0;
  localparam int unsigned PAR_EVEN = 1;
  localparam int unsigned PAR_ODD  = 2;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StData = 2'd1,
    StPar  = 2'd2,
    StStop = 2'd3
  } ser_state_e;

  // Words narrower than 9 bits are zero-extended, which leaves the XOR unchanged.
  function automatic logic parity_bit(input logic [8:0] word, input int unsigned mode);
    return (mode == PAR_ODD) ? ~(^word) : ^word;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with occupancy count; the count tells full from empty.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16,
  localparam int unsigned AW = $clog2(DEPTH),
  localparam int unsigned CW = AW + 1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic [CW-1:0]    o_count,
  output logic             o_full,
  output logic             o_empty
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_full    = (r_count == CW'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign o_data    = r_mem[r_rd_ptr];
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage array, no reset needed since the count gates every read.
  always_ff @(posedge i_clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_data;
  end

endmodule

// File: rtl/uart_tx_buffered.sv
// Buffered UART transmitter: FIFO in front of a bit_tick-paced frame serialiser.
module uart_tx_buffered
  import uart_pkg::*;
#(
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned PARITY     = 0,
  parameter int unsigned STOP_BITS  = 1,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic                        CLK,
  input  logic                        rst,
  input  logic                        bit_tick,
  input  logic [DATA_BITS-1:0]        data_in,
  input  logic                        valid_in,
  output logic                        ready,
  output logic                        TX,
  output logic                        busy,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

  localparam int unsigned IDX_W = $clog2(DATA_BITS);

  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
    $error("uart_tx_buffered: DATA_BITS must be 5..9");
  end
  if (PARITY > PAR_ODD) begin : g_bad_parity
    $error("uart_tx_buffered: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
    $error("uart_tx_buffered: STOP_BITS must be 1 or 2");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("uart_tx_buffered: FIFO_DEPTH must be a power of two >= 2");
  end

  ser_state_e           r_state, w_state_next;
  logic [DATA_BITS-1:0] r_shreg, w_shreg_next;
  logic                 r_par_bit, w_par_next;
  logic [IDX_W-1:0]     r_bit_idx, w_bit_idx_next;
  logic [1:0]           r_stop_cnt, w_stop_cnt_next;
  logic                 r_tx, w_tx_next;
  logic                 r_busy, w_busy_next;
  logic                 w_load;
  logic                 w_pop;
  logic                 w_push;
  logic [DATA_BITS-1:0] w_fifo_data;
  logic                 w_fifo_full;
  logic                 w_fifo_empty;

  assign ready  = !w_fifo_full;
  assign w_push = valid_in && ready;
  assign TX     = r_tx;
  assign busy   = r_busy;

  sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk   (CLK),
    .i_rst   (rst),
    .i_push  (w_push),
    .i_data  (data_in),
    .i_pop   (w_pop),
    .o_data  (w_fifo_data),
    .o_count (fifo_count),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty)
  );

  // Serialiser next state: every move happens on bit_tick. The tick that ends the
  // last stop bit also launches the next start bit when a word is waiting.
  always_comb begin
    w_state_next    = r_state;
    w_shreg_next    = r_shreg;
    w_par_next      = r_par_bit;
    w_bit_idx_next  = r_bit_idx;
    w_stop_cnt_next = r_stop_cnt;
    w_tx_next       = r_tx;
    w_load          = 1'b0;
    w_pop           = 1'b0;
    if (bit_tick) begin
      unique case (r_state)
        StIdle: w_load = !w_fifo_empty;
        StData: begin
          w_tx_next      = r_shreg[0];
          w_shreg_next   = r_shreg >> 1;
          w_bit_idx_next = r_bit_idx + 1'b1;
          if (r_bit_idx == IDX_W'(DATA_BITS - 1)) begin
            w_stop_cnt_next = '0;
            w_state_next    = (PARITY != PAR_NONE) ? StPar : StStop;
          end
        end
        StPar: begin
          w_tx_next    = r_par_bit;
          w_state_next = StStop;
        end
        StStop: begin
          if (r_stop_cnt == 2'(STOP_BITS)) begin
            // All stop bits have run their full period.
            w_load = !w_fifo_empty;
            if (w_fifo_empty) begin
              w_tx_next    = 1'b1;
              w_state_next = StIdle;
            end
          end else begin
            w_tx_next       = 1'b1;
            w_stop_cnt_next = r_stop_cnt + 1'b1;
          end
        end
        default: w_state_next = StIdle;
      endcase
      if (w_load) begin
        w_pop          = 1'b1;
        w_shreg_next   = w_fifo_data;
        w_par_next     = parity_bit(9'(w_fifo_data), PARITY);
        w_tx_next      = 1'b0;
        w_bit_idx_next = '0;
        w_state_next   = StData;
      end
    end
    w_busy_next = (w_state_next != StIdle);
  end

  // Serialiser registers; reset aborts any frame and parks the line high.
  always_ff @(posedge CLK) begin
    if (rst) begin
      r_state    <= StIdle;
      r_shreg    <= '0;
      r_par_bit  <= 1'b0;
      r_bit_idx  <= '0;
      r_stop_cnt <= '0;
      r_tx       <= 1'b1;
      r_busy     <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_shreg    <= w_shreg_next;
      r_par_bit  <= w_par_next;
      r_bit_idx  <= w_bit_idx_next;
      r_stop_cnt <= w_stop_cnt_next;
      r_tx       <= w_tx_next;
      r_busy     <= w_busy_next;
    end
  end

endmodule
